// File: rtl/bcd_stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch: digit geometry, digit limits,
// control-state encoding and the packed four-digit display word.
package bcd_stopwatch_pkg;

  localparam int unsigned DIGIT_W      = 4;
  localparam int unsigned NUM_DIGITS   = 4;
  localparam int unsigned WORD_W       = DIGIT_W * NUM_DIGITS;
  localparam int unsigned DIGIT_MAX_LO = 9;
  localparam int unsigned DIGIT_MAX_HI = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LAP   = 2'd2,
    ST_PAUSE = 2'd3
  } state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
    logic [DIGIT_W-1:0] tenths;
    logic [DIGIT_W-1:0] hundredths;
  } bcd_word_t;

endpackage

// File: rtl/bcd_stopwatch_if.sv
// Button inputs and display/status outputs of the stopwatch, grouped as one bundle.
interface bcd_stopwatch_if;
  import bcd_stopwatch_pkg::*;

  logic              startStop;
  logic              clear;
  logic              lap;
  logic [WORD_W-1:0] digits;
  logic              running;
  logic              lapActive;
  logic              overflow;

  modport master (
    output startStop, clear, lap,
    input  digits, running, lapActive, overflow
  );

  modport slave (
    input  startStop, clear, lap,
    output digits, running, lapActive, overflow
  );

endinterface

// File: rtl/bcd_digit_ctr.sv
// Single BCD digit counter wrapping MAX -> 0; carry flags the wrapping increment.
module bcd_digit_ctr
  import bcd_stopwatch_pkg::*;
#(
  parameter int unsigned MAX = DIGIT_MAX_LO
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);

  logic at_max;

  assign at_max = (q == DIGIT_W'(MAX));
  assign carry  = inc & at_max;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= at_max ? '0 : q + DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/bcd_stopwatch.sv
// Seconds/hundredths stopwatch: button sync + edge detect, run/lap/pause control,
// prescaled BCD count 00.00..59.99 with sticky wrap flag and registered display.
module bcd_stopwatch
  import bcd_stopwatch_pkg::*;
#(
  parameter int unsigned CLK_DIV = 500000
) (
  input  logic                  clk,
  input  logic                  resetn,
  bcd_stopwatch_if.slave        bus
);

  localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned NBTN  = 3;

  // Button index order: 0 startStop, 1 clear, 2 lap
  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] btn_s1;
  logic [NBTN-1:0] btn_s2;
  logic [NBTN-1:0] btn_dly;
  logic [NBTN-1:0] btn_ev;
  logic            ss_ev;
  logic            clr_ev;
  logic            lap_ev;

  state_e state_q;
  state_e state_d;
  logic   lap_load;
  logic   clr_go;

  logic [DIV_W-1:0] div_q;
  logic             counting;
  logic             tick;

  logic [DIGIT_W-1:0] hund_q;
  logic [DIGIT_W-1:0] tenth_q;
  logic [DIGIT_W-1:0] ones_q;
  logic [DIGIT_W-1:0] tens_q;
  logic               hund_cy;
  logic               tenth_cy;
  logic               ones_cy;
  logic               wrap;
  bcd_word_t          cnt;
  bcd_word_t          lap_q;

  logic [WORD_W-1:0] digits_q;
  logic              running_q;
  logic              lap_active_q;
  logic              overflow_q;

  assign btn_raw = {bus.lap, bus.clear, bus.startStop};

  // Two-stage synchroniser plus delay flop per button
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      btn_s1  <= '0;
      btn_s2  <= '0;
      btn_dly <= '0;
    end else begin
      btn_s1  <= btn_raw;
      btn_s2  <= btn_s1;
      btn_dly <= btn_s2;
    end
  end

  assign btn_ev = btn_s2 & ~btn_dly;
  assign ss_ev  = btn_ev[0];
  assign clr_ev = btn_ev[1];
  assign lap_ev = btn_ev[2];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Only the highest-priority event legal in the current state acts (clear > startStop > lap)
  always_comb begin
    state_d  = state_q;
    lap_load = 1'b0;
    clr_go   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ss_ev) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ss_ev) begin
          state_d = ST_PAUSE;
        end else if (lap_ev) begin
          state_d  = ST_LAP;
          lap_load = 1'b1;
        end
      end
      ST_LAP: begin
        if (ss_ev)       state_d = ST_PAUSE;
        else if (lap_ev) state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (clr_ev) begin
          state_d = ST_IDLE;
          clr_go  = 1'b1;
        end else if (ss_ev) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign tick     = counting && (div_q == DIV_W'(CLK_DIV - 1));

  // Prescaler: frozen in PAUSE so a partial tick survives a pause/resume
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q <= '0;
    end else if (clr_go || (state_q == ST_IDLE) || tick) begin
      div_q <= '0;
    end else if (counting) begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  bcd_digit_ctr #(.MAX(DIGIT_MAX_LO)) u_hund (
    .clk(clk), .resetn(resetn), .clr(clr_go), .inc(tick),
    .q(hund_q), .carry(hund_cy)
  );

  bcd_digit_ctr #(.MAX(DIGIT_MAX_LO)) u_tenth (
    .clk(clk), .resetn(resetn), .clr(clr_go), .inc(hund_cy),
    .q(tenth_q), .carry(tenth_cy)
  );

  bcd_digit_ctr #(.MAX(DIGIT_MAX_LO)) u_ones (
    .clk(clk), .resetn(resetn), .clr(clr_go), .inc(tenth_cy),
    .q(ones_q), .carry(ones_cy)
  );

  bcd_digit_ctr #(.MAX(DIGIT_MAX_HI)) u_tens (
    .clk(clk), .resetn(resetn), .clr(clr_go), .inc(ones_cy),
    .q(tens_q), .carry(wrap)
  );

  assign cnt = {tens_q, ones_q, tenth_q, hund_q};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lap_q        <= '0;
      digits_q     <= '0;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      if (lap_load) lap_q <= cnt;
      digits_q     <= (state_q == ST_LAP) ? lap_q : cnt;
      running_q    <= (state_d == ST_RUN) || (state_d == ST_LAP);
      lap_active_q <= (state_d == ST_LAP);
      if (clr_go)    overflow_q <= 1'b0;
      else if (wrap) overflow_q <= 1'b1;
    end
  end

  assign bus.digits    = digits_q;
  assign bus.running   = running_q;
  assign bus.lapActive = lap_active_q;
  assign bus.overflow  = overflow_q;

endmodule
